// File: rtl/msrv_32_decode_queue.sv
// MSRV32 instruction decoder followed by a DEPTH-entry FIFO of decoded control bundles.
// Optional M-extension decode, trap flush and a saturating illegal-instruction counter.
module msrv_32_decode_queue #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned M_EXT = 0,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [31:0]      instr_in,
  input  logic [1:0]       iadder_out_1_to_0_in,
  input  logic             instr_valid_in,
  output logic             instr_ready_out,
  input  logic             trap_taken_in,
  output logic             dec_valid_out,
  input  logic             dec_ready_in,
  output logic [2:0]       wb_mux_sel_out,
  output logic [2:0]       imm_type_out,
  output logic [2:0]       csr_op_out,
  output logic [3+M_EXT:0] alu_opcode_out,
  output logic [1:0]       load_size_out,
  output logic             load_unsigned_out,
  output logic             mem_wr_req_out,
  output logic             alu_src_out,
  output logic             iadder_src_out,
  output logic             csr_wr_en_out,
  output logic             rf_wr_en_out,
  output logic             illegal_instr_out,
  output logic             misaligned_load_out,
  output logic             misaligned_store_out,
  output logic [CNT_W-1:0] illegal_count_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int ALU_W = 4 + M_EXT;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    WB_ALU, WB_LOAD, WB_IMM, WB_IADDER, WB_CSR, WB_PC4
  } wb_sel_e;

  typedef enum logic [2:0] {
    IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_CSR
  } imm_type_e;

  typedef struct packed {
    wb_sel_e          wb_sel;
    imm_type_e        imm_type;
    logic [2:0]       csr_op;
    logic [ALU_W-1:0] alu_opcode;
    logic [1:0]       load_size;
    logic             load_unsigned;
    logic             mem_wr_req;
    logic             alu_src;
    logic             iadder_src;
    logic             csr_wr_en;
    logic             rf_wr_en;
    logic             illegal;
    logic             mis_load;
    logic             mis_store;
  } bundle_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       addr_misaligned;
  bundle_t    dec;

  assign opcode = instr_in[6:0];
  assign funct3 = instr_in[14:12];
  assign funct7 = instr_in[31:25];
  // Word access needs addr[1:0]==0, halfword needs addr[0]==0; byte access never misaligns.
  assign addr_misaligned = (funct3[1:0] == 2'b10 && iadder_out_1_to_0_in != 2'b00) ||
                           (funct3[1:0] == 2'b01 && iadder_out_1_to_0_in[0]);

  // NOTE: every field gets a default before the case so no path can infer a latch.
  always_comb begin
    dec               = '0;
    dec.alu_opcode    = ALU_W'(funct3);
    dec.load_size     = funct3[1:0];
    dec.load_unsigned = funct3[2];
    unique case (opcode)
      OPC_LOAD: begin
        dec.wb_sel     = WB_LOAD;
        dec.imm_type   = IMM_I;
        dec.iadder_src = 1'b1;
        dec.rf_wr_en   = 1'b1;
        dec.illegal    = funct3 inside {3'd3, 3'd6, 3'd7};
        dec.mis_load   = addr_misaligned;
      end
      OPC_STORE: begin
        dec.imm_type   = IMM_S;
        dec.iadder_src = 1'b1;
        dec.mem_wr_req = 1'b1;
        dec.illegal    = funct3 > 3'd2;
        dec.mis_store  = addr_misaligned;
      end
      OPC_BRANCH: begin
        dec.imm_type = IMM_B;
        dec.alu_src  = 1'b1;
        dec.illegal  = funct3 inside {3'd2, 3'd3};
      end
      OPC_OP_IMM: begin
        dec.imm_type = IMM_I;
        dec.rf_wr_en = 1'b1;
        if (funct3 == 3'd1) begin
          dec.illegal = funct7 != 7'b0000000;
        end else if (funct3 == 3'd5) begin
          dec.illegal       = !(funct7 == 7'b0000000 || funct7 == 7'b0100000);
          dec.alu_opcode[3] = funct7[5];
        end
      end
      OPC_OP: begin
        dec.alu_src  = 1'b1;
        dec.rf_wr_en = 1'b1;
        if (funct7 == 7'b0100000 && (funct3 == 3'd0 || funct3 == 3'd5)) begin
          dec.alu_opcode[3] = 1'b1;
        end else if (funct7 == 7'b0000001 && M_EXT != 0) begin
          dec.alu_opcode = dec.alu_opcode | ALU_W'(5'b1_0000);
        end else if (funct7 != 7'b0000000) begin
          dec.illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        dec.wb_sel   = WB_IMM;
        dec.imm_type = IMM_U;
        dec.rf_wr_en = 1'b1;
      end
      OPC_AUIPC: begin
        dec.wb_sel   = WB_IADDER;
        dec.imm_type = IMM_U;
        dec.rf_wr_en = 1'b1;
      end
      OPC_JAL: begin
        dec.wb_sel   = WB_PC4;
        dec.imm_type = IMM_J;
        dec.rf_wr_en = 1'b1;
      end
      OPC_JALR: begin
        dec.wb_sel     = WB_PC4;
        dec.imm_type   = IMM_I;
        dec.iadder_src = 1'b1;
        dec.rf_wr_en   = 1'b1;
      end
      OPC_MISC: dec.imm_type = IMM_I;
      OPC_SYSTEM: begin
        dec.wb_sel    = WB_CSR;
        dec.imm_type  = IMM_CSR;
        dec.csr_op    = funct3;
        dec.csr_wr_en = funct3 != 3'd0;
        dec.rf_wr_en  = funct3 != 3'd0;
        dec.illegal   = funct3 == 3'd4;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal) begin
      dec.rf_wr_en   = 1'b0;
      dec.csr_wr_en  = 1'b0;
      dec.mem_wr_req = 1'b0;
    end
    if (dec.mis_load)  dec.rf_wr_en   = 1'b0;
    if (dec.mis_store) dec.mem_wr_req = 1'b0;
  end

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;
  bundle_t          mem_q [DEPTH];
  logic             push, pop, full;

  assign full = occ_q == OCC_W'(DEPTH);
  assign push = instr_valid_in && !full;
  assign pop  = (occ_q != '0) && dec_ready_in;

  // Trap flush wins over everything; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    ill_cnt_d = ill_cnt_q;
    if (trap_taken_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
      if (push && dec.illegal && ill_cnt_q != {CNT_W{1'b1}}) ill_cnt_d = ill_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      ill_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end

  // NOTE: storage has no reset; outputs are gated by occupancy so stale entries are never seen.
  always_ff @(posedge clk_in) begin
    if (push && !trap_taken_in) mem_q[wr_ptr_q] <= dec;
  end

  bundle_t head;
  assign dec_valid_out   = occ_q != '0;
  assign instr_ready_out = !full;
  assign head            = dec_valid_out ? mem_q[rd_ptr_q] : '0;

  assign wb_mux_sel_out       = head.wb_sel;
  assign imm_type_out         = head.imm_type;
  assign csr_op_out           = head.csr_op;
  assign alu_opcode_out       = head.alu_opcode;
  assign load_size_out        = head.load_size;
  assign load_unsigned_out    = head.load_unsigned;
  assign mem_wr_req_out       = head.mem_wr_req;
  assign alu_src_out          = head.alu_src;
  assign iadder_src_out       = head.iadder_src;
  assign csr_wr_en_out        = head.csr_wr_en;
  assign rf_wr_en_out         = head.rf_wr_en;
  assign illegal_instr_out    = head.illegal;
  assign misaligned_load_out  = head.mis_load;
  assign misaligned_store_out = head.mis_store;
  assign illegal_count_out    = ill_cnt_q;

  // Register specifiers are consumed downstream from the raw word, not by this block.
  logic unused_instr_bits;
  assign unused_instr_bits = &{1'b0, instr_in[24:15], instr_in[11:7]};

endmodule

// File: tb/tb_msrv_32_decode_queue.sv
// Directed bench for msrv_32_decode_queue: decode table on M_EXT=0 and M_EXT=1 instances,
// plus hand sequences for fill/backpressure, trap flush, counter saturation and async reset.
module tb_msrv_32_decode_queue;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] instr_in;
  logic [1:0]  addr_in;
  logic        instr_valid_in, trap_taken_in, dec_ready_in;

  logic       rdy0, vld0, ldu0, mem0, src0, iad0, cwr0, rf0, ill0, ml0, ms0;
  logic [2:0] wb0, imm0, csr0;
  logic [3:0] alu0;
  logic [1:0] lsz0;
  logic [7:0] cnt0;

  logic       rdy1, vld1, ldu1, mem1, src1, iad1, cwr1, rf1, ill1, ml1, ms1;
  logic [2:0] wb1, imm1, csr1;
  logic [4:0] alu1;
  logic [1:0] lsz1;
  logic [7:0] cnt1;

  always #5 clk_in = ~clk_in;

  msrv_32_decode_queue #(.DEPTH(2), .M_EXT(0), .CNT_W(8)) u0 (
    .clk_in(clk_in), .rst_in(rst_in), .instr_in(instr_in), .iadder_out_1_to_0_in(addr_in),
    .instr_valid_in(instr_valid_in), .instr_ready_out(rdy0), .trap_taken_in(trap_taken_in),
    .dec_valid_out(vld0), .dec_ready_in(dec_ready_in), .wb_mux_sel_out(wb0),
    .imm_type_out(imm0), .csr_op_out(csr0), .alu_opcode_out(alu0), .load_size_out(lsz0),
    .load_unsigned_out(ldu0), .mem_wr_req_out(mem0), .alu_src_out(src0),
    .iadder_src_out(iad0), .csr_wr_en_out(cwr0), .rf_wr_en_out(rf0),
    .illegal_instr_out(ill0), .misaligned_load_out(ml0), .misaligned_store_out(ms0),
    .illegal_count_out(cnt0)
  );

  msrv_32_decode_queue #(.DEPTH(2), .M_EXT(1), .CNT_W(8)) u1 (
    .clk_in(clk_in), .rst_in(rst_in), .instr_in(instr_in), .iadder_out_1_to_0_in(addr_in),
    .instr_valid_in(instr_valid_in), .instr_ready_out(rdy1), .trap_taken_in(trap_taken_in),
    .dec_valid_out(vld1), .dec_ready_in(dec_ready_in), .wb_mux_sel_out(wb1),
    .imm_type_out(imm1), .csr_op_out(csr1), .alu_opcode_out(alu1), .load_size_out(lsz1),
    .load_unsigned_out(ldu1), .mem_wr_req_out(mem1), .alu_src_out(src1),
    .iadder_src_out(iad1), .csr_wr_en_out(cwr1), .rf_wr_en_out(rf1),
    .illegal_instr_out(ill1), .misaligned_load_out(ml1), .misaligned_store_out(ms1),
    .illegal_count_out(cnt1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Bundle layout: {wb, imm, csr_op, alu[3:0], alu_src, iadder_src, rf, mem, csr_wr, ill, ml, ms}
  function automatic logic [20:0] mk(input logic [2:0] wb, input logic [2:0] imm,
                                     input logic [2:0] csr, input logic [3:0] alu,
                                     input logic src, input logic iad, input logic rf,
                                     input logic mem, input logic cwr, input logic ill,
                                     input logic ml, input logic ms);
    return {wb, imm, csr, alu, src, iad, rf, mem, cwr, ill, ml, ms};
  endfunction

  function automatic logic [20:0] pack0();
    return {wb0, imm0, csr0, alu0, src0, iad0, rf0, mem0, cwr0, ill0, ml0, ms0};
  endfunction

  function automatic logic [21:0] pack1();
    return {wb1, imm1, csr1, alu1, src1, iad1, rf1, mem1, cwr1, ill1, ml1, ms1};
  endfunction

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [1:0]  addr;
    logic [20:0] exp;
    logic        m_legal;  // legal MUL/DIV on the M_EXT=1 instance
  } vec_t;

  localparam logic [31:0] I_ADD  = 32'h003100B3;
  localparam logic [31:0] I_SUB  = 32'h403100B3;
  localparam logic [31:0] I_SRAI = 32'h4031D093;
  localparam logic [31:0] I_LW   = 32'h0000A083;
  localparam logic [31:0] I_ZERO = 32'h00000000;

  vec_t vecs [21];

  initial begin
    logic [21:0] e1;

    vecs[0]  = '{"add",      I_ADD,        2'd0, mk(0,0,0,4'b0000,1,0,1,0,0,0,0,0), 1'b0};
    vecs[1]  = '{"sub",      I_SUB,        2'd0, mk(0,0,0,4'b1000,1,0,1,0,0,0,0,0), 1'b0};
    vecs[2]  = '{"srai",     I_SRAI,       2'd0, mk(0,1,0,4'b1101,0,0,1,0,0,0,0,0), 1'b0};
    vecs[3]  = '{"sra",      32'h4031D0B3, 2'd0, mk(0,0,0,4'b1101,1,0,1,0,0,0,0,0), 1'b0};
    vecs[4]  = '{"lw_mis",   I_LW,         2'd2, mk(1,1,0,4'b0010,0,1,0,0,0,0,1,0), 1'b0};
    vecs[5]  = '{"lw_ok",    I_LW,         2'd0, mk(1,1,0,4'b0010,0,1,1,0,0,0,0,0), 1'b0};
    vecs[6]  = '{"lh_mis",   32'h00009083, 2'd1, mk(1,1,0,4'b0001,0,1,0,0,0,0,1,0), 1'b0};
    vecs[7]  = '{"sw_mis",   32'h0020A023, 2'd1, mk(0,2,0,4'b0010,0,1,0,0,0,0,0,1), 1'b0};
    vecs[8]  = '{"sh_ok",    32'h00209023, 2'd2, mk(0,2,0,4'b0001,0,1,0,1,0,0,0,0), 1'b0};
    vecs[9]  = '{"zero",     I_ZERO,       2'd0, mk(0,0,0,4'b0000,0,0,0,0,0,1,0,0), 1'b0};
    vecs[10] = '{"mul",      32'h023100B3, 2'd0, mk(0,0,0,4'b0000,1,0,0,0,0,1,0,0), 1'b1};
    vecs[11] = '{"lui",      32'h100000B7, 2'd0, mk(2,4,0,4'b0000,0,0,1,0,0,0,0,0), 1'b0};
    vecs[12] = '{"auipc",    32'h00000097, 2'd0, mk(3,4,0,4'b0000,0,0,1,0,0,0,0,0), 1'b0};
    vecs[13] = '{"jal",      32'h000000EF, 2'd0, mk(5,5,0,4'b0000,0,0,1,0,0,0,0,0), 1'b0};
    vecs[14] = '{"jalr",     32'h000080E7, 2'd0, mk(5,1,0,4'b0000,0,1,1,0,0,0,0,0), 1'b0};
    vecs[15] = '{"beq",      32'h00208063, 2'd0, mk(0,3,0,4'b0000,1,0,0,0,0,0,0,0), 1'b0};
    vecs[16] = '{"br_f3_2",  32'h0020A063, 2'd0, mk(0,3,0,4'b0010,1,0,0,0,0,1,0,0), 1'b0};
    vecs[17] = '{"csrrw",    32'h340110F3, 2'd0, mk(4,6,1,4'b0001,0,0,1,0,1,0,0,0), 1'b0};
    vecs[18] = '{"sys_f3_4", 32'h340140F3, 2'd0, mk(4,6,4,4'b0100,0,0,0,0,0,1,0,0), 1'b0};
    vecs[19] = '{"slli_bad", 32'h40109093, 2'd0, mk(0,1,0,4'b0001,0,0,0,0,0,1,0,0), 1'b0};
    vecs[20] = '{"or_bad",   32'h403160B3, 2'd0, mk(0,0,0,4'b0110,1,0,0,0,0,1,0,0), 1'b0};

    rst_in = 1'b1; instr_in = '0; addr_in = '0;
    instr_valid_in = 1'b0; trap_taken_in = 1'b0; dec_ready_in = 1'b0;

    // Reset state
    #12;
    check("rst_valid", 32'(vld0), 32'd0);
    check("rst_count", 32'(cnt0), 32'd0);
    check("rst_bundle", 32'(pack0()), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    check("rst_ready", 32'(rdy0), 32'd1);

    // Decode table: push one, inspect head on both instances, pop, confirm empty outputs
    foreach (vecs[i]) begin
      instr_in = vecs[i].instr; addr_in = vecs[i].addr;
      instr_valid_in = 1'b1; dec_ready_in = 1'b0;
      step();
      instr_valid_in = 1'b0;
      check({vecs[i].name, "_valid"}, 32'(vld0), 32'd1);
      check({vecs[i].name, "_m0"}, 32'(pack0()), 32'(vecs[i].exp));
      e1 = {vecs[i].exp[20:12], vecs[i].m_legal, vecs[i].exp[11:0]};
      if (vecs[i].m_legal) begin
        e1[5] = 1'b1;
        e1[2] = 1'b0;
      end
      check({vecs[i].name, "_m1"}, 32'(pack1()), 32'(e1));
      dec_ready_in = 1'b1;
      step();
      dec_ready_in = 1'b0;
      check({vecs[i].name, "_empty"}, 32'({vld0, pack0()}), 32'd0);
    end
    check("ill_count_m0", 32'(cnt0), 32'd6);
    check("ill_count_m1", 32'(cnt1), 32'd5);

    // Fill to DEPTH, backpressure, no bypass when full
    instr_in = I_SUB; instr_valid_in = 1'b1;
    step();
    check("fill1_ready", 32'(rdy0), 32'd1);
    instr_in = I_SRAI;
    step();
    check("full_ready", 32'(rdy0), 32'd0);
    instr_in = I_LW; addr_in = 2'b10;
    step();
    check("full_hold_ready", 32'(rdy0), 32'd0);
    check("full_hold_alu", 32'(alu0), 32'b1000);
    dec_ready_in = 1'b1;
    step();
    check("nobypass_ready", 32'(rdy0), 32'd1);
    check("srai_head", 32'({alu0, src0}), 32'b1101_0);
    dec_ready_in = 1'b0;
    step();
    instr_valid_in = 1'b0; addr_in = 2'b00;
    check("lw_in_ready", 32'(rdy0), 32'd0);
    check("srai_stable", 32'(alu0), 32'b1101);
    dec_ready_in = 1'b1;
    step();
    check("lw_head", 32'({ml0, rf0}), 32'b10);
    step();
    check("drained", 32'(vld0), 32'd0);
    dec_ready_in = 1'b0;

    // Simultaneous push and pop at occupancy 1
    instr_in = I_ADD; instr_valid_in = 1'b1;
    step();
    instr_in = I_SUB; dec_ready_in = 1'b1;
    step();
    instr_valid_in = 1'b0;
    check("pushpop_state", 32'({vld0, rdy0, alu0}), 32'b11_1000);
    step();
    dec_ready_in = 1'b0;
    check("pushpop_drain", 32'(vld0), 32'd0);

    // Trap flush with a full queue and a pending illegal push
    instr_in = I_ADD; instr_valid_in = 1'b1;
    step();
    step();
    check("trap_full", 32'(rdy0), 32'd0);
    instr_in = I_ZERO; trap_taken_in = 1'b1;
    step();
    trap_taken_in = 1'b0; instr_valid_in = 1'b0;
    check("trap_state", 32'({vld0, rdy0}), 32'b01);
    check("trap_bundle", 32'(pack0()), 32'd0);
    check("trap_count", 32'(cnt0), 32'd6);

    // Trap with room: the same-cycle illegal push is discarded
    instr_in = I_ADD; instr_valid_in = 1'b1;
    step();
    instr_in = I_ZERO; trap_taken_in = 1'b1;
    step();
    trap_taken_in = 1'b0; instr_valid_in = 1'b0;
    step();
    check("trap2_valid", 32'(vld0), 32'd0);
    check("trap2_count", 32'(cnt0), 32'd6);

    // Counter saturation, then asynchronous reset between edges
    instr_in = I_ZERO; instr_valid_in = 1'b1; dec_ready_in = 1'b1;
    for (int k = 0; k < 260; k++) step();
    check("sat_count", 32'(cnt0), 32'd255);
    check("sat_valid", 32'(vld0), 32'd1);
    #2 rst_in = 1'b1;
    #1;
    check("async_rst_count", 32'(cnt0), 32'd0);
    check("async_rst_valid", 32'(vld0), 32'd0);
    instr_valid_in = 1'b0; dec_ready_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    check("post_rst_ready", 32'(rdy0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
